// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift-register arbiter controller.
// Contents: controller state enum and requester id (used as the priority flag).
// No logic; imported by the controller and its shift register.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TX_SHIFT = 2'd1,
    RX_SHIFT = 2'd2,
    RX_HOLD  = 2'd3
  } ctrl_state_t;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_id_t;

endpackage

// File: rtl/shift_reg_arbiter_ctrl_sreg.sv
// Parallel/serial shift register: parallel load when SEL=0, shift right when SEL=1.
// Latency: one clock; Din_serie enters the MSB on a shift.
// Backpressure: none; the register is loaded or shifted every cycle.
// Ports: clk, reset (async, active-high), SEL, Din_serie, Din[WIDTH], Dout[WIDTH].
module RegistradorPareleloSerial
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SEL,
  input  logic             Din_serie,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (SEL) begin
      data_q <= {Din_serie, data_q[WIDTH-1:1]};
    end else begin
      data_q <= Din;
    end
  end

  assign Dout = data_q;

endmodule

// File: rtl/shift_reg_arbiter_ctrl.sv
// Shares one shift register between a TX producer and an RX consumer, round-robin.
// Latency: TX accept in the grant cycle, N_BITS*BIT_CYCLES shift cycles, then IDLE.
// Backpressure: received word holds in RX_HOLD until rx_ready; tx_ready only in IDLE.
// Ports: clk, reset, tx_valid/tx_data/tx_ready, rx_req, rx_valid/rx_data/rx_ready,
//        serial_in, serial_out (idle high), busy.
module shift_reg_arbiter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N_BITS     = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [N_BITS-1:0] tx_data,
  output logic              tx_ready,
  input  logic              rx_req,
  output logic              rx_valid,
  output logic [N_BITS-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              busy
);

  localparam int BW = $clog2(N_BITS + 1);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  ctrl_state_t       state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [CW-1:0]     cyc_cnt_q;
  req_id_t           prio_q;
  logic              busy_q;
  logic              rx_valid_q;

  logic [N_BITS-1:0] sr_dout;
  logic [N_BITS-1:0] sr_din;
  logic              sr_sel;
  logic              sr_din_serie;

  logic              in_idle;
  logic              grant_tx;
  logic              grant_rx;
  logic              bit_end;
  logic              last_bit;

  always_comb begin
    in_idle  = (state_q == IDLE) && !reset;
    grant_tx = in_idle && tx_valid && (!rx_req || (prio_q == REQ_TX));
    grant_rx = in_idle && rx_req && (!tx_valid || (prio_q == REQ_RX));
    // A bit period ends on the last cycle of its BIT_CYCLES window.
    bit_end  = ((state_q == TX_SHIFT) || (state_q == RX_SHIFT)) && (cyc_cnt_q == CYC_LAST);
    last_bit = bit_end && (bit_cnt_q == BIT_LAST);
    // Outside a shift the register reloads itself, which is how it holds.
    sr_sel       = bit_end;
    sr_din_serie = (state_q == RX_SHIFT) && serial_in;
    sr_din       = grant_tx ? tx_data : sr_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      prio_q     <= REQ_TX;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_tx) begin
            state_q <= TX_SHIFT;
            busy_q  <= 1'b1;
          end else if (grant_rx) begin
            state_q <= RX_SHIFT;
            busy_q  <= 1'b1;
          end
          if (grant_tx || grant_rx) begin
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            prio_q    <= grant_tx ? REQ_RX : REQ_TX;
          end
        end
        TX_SHIFT, RX_SHIFT: begin
          if (bit_end) begin
            cyc_cnt_q <= '0;
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
          if (last_bit) begin
            if (state_q == TX_SHIFT) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= RX_HOLD;
              rx_valid_q <= 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (rx_ready) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  RegistradorPareleloSerial #(.WIDTH(N_BITS)) u_sreg (
    .clk      (clk),
    .reset    (reset),
    .SEL      (sr_sel),
    .Din_serie(sr_din_serie),
    .Din      (sr_din),
    .Dout     (sr_dout)
  );

  assign tx_ready   = grant_tx;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = sr_dout;
  assign busy       = busy_q;
  assign serial_out = (state_q == TX_SHIFT) ? sr_dout[0] : 1'b1;

endmodule

// File: doc/shift_reg_arbiter_ctrl.md
# shift_reg_arbiter_ctrl

Controller that shares one N_BITS parallel/serial shift register between a transmit requester and a receive requester. It sequences the register through parallel load, LSB-first serial shift-out, serial shift-in, and hold. Round-robin arbitration decides which requester gets the register. It sits between the parallel-word producer/consumer logic and the single-wire serial link.

## Interface
- N_BITS, 4, word width; also the shift register width
- BIT_CYCLES, 1, clock cycles per serial bit (>= 1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- tx_valid  in  1  producer has a word to send
- tx_data  in  N_BITS  word to send
- tx_ready  out  1  word accepted this cycle
- rx_req  in  1  consumer requests a word; level, held until the word is taken
- rx_valid  out  1  received word available
- rx_data  out  N_BITS  received word
- rx_ready  in  1  consumer takes the word
- serial_in  in  1  serial receive line
- serial_out  out  1  serial transmit line; idle high
- busy  out  1  state != IDLE

## Operation
- States: IDLE, TX_SHIFT, RX_SHIFT, RX_HOLD.
- Hold behaviour: the register reloads its parallel input every non-shift cycle. In every cycle that is neither a load nor a shift, the controller drives the parallel input with the register's own output.
- IDLE and arbitration:
  - Requests: tx_valid for TX, rx_req for RX.
  - One request only: that requester wins.
  - Both requests: the requester holding priority wins. Priority flips to the other requester after every grant. Reset gives TX priority.
- TX grant:
  - tx_ready = 1 combinationally in that IDLE cycle.
  - Register loads tx_data.
  - Next state TX_SHIFT.
- TX_SHIFT:
  - serial_out = reg[0].
  - Each bit lasts BIT_CYCLES cycles. On the last cycle of a bit, the register shifts right with 0 entering the MSB.
  - After N_BITS bits, go to IDLE.
- RX grant:
  - Next state RX_SHIFT.
  - Register unchanged; no ready pulse.
- RX_SHIFT:
  - On the last cycle of each bit period, shift right with serial_in entering the MSB.
  - After N_BITS shifts, the first received bit is in reg[0].
  - Next state RX_HOLD.
- RX_HOLD:
  - rx_valid = 1; rx_data = register, stable.
  - On rx_valid & rx_ready, go to IDLE.
  - rx_req is re-evaluated only from IDLE.
- Outside RX_HOLD: rx_valid = 0 and rx_data = register value (don't-care).
- Outside TX_SHIFT: serial_out = 1.
- Counters:
  - Bit counter: $clog2(N_BITS+1) bits.
  - Cycle counter: max(1, $clog2(BIT_CYCLES)) bits.
  - Both clear on every grant.
- Reset (asynchronous, at any point including mid-shift):
  - state IDLE, register 0, counters 0, priority TX.
  - serial_out 1; tx_ready, rx_valid and busy 0.
  - Any partial word is discarded.

## Timing
- TX latency:
  - Accept in cycle 0.
  - Bit k is driven in cycles 1+k·BIT_CYCLES through (k+1)·BIT_CYCLES.
  - IDLE returns in cycle N_BITS·BIT_CYCLES+1, which is the earliest next grant.
- RX latency:
  - Grant in cycle 0.
  - Bit k is sampled at the end of cycle (k+1)·BIT_CYCLES.
  - rx_valid is high from cycle N_BITS·BIT_CYCLES+1.
  - After the rx_ready handshake, IDLE is entered on the next cycle.
- Exactly one IDLE cycle separates consecutive grants; serial_out = 1 in that cycle.
- tx_ready depends combinationally on tx_valid, rx_req and the priority flag. No other output is combinational on inputs.

## Structure
- Package shift_ctrl_pkg:
  - state enum typedef (ctrl_state_t)
  - requester-id typedef used for the priority flag
- One sub-module: the team's parallel/serial shift register (RegistradorPareleloSerial, width N_BITS).
  - The controller drives its SEL, Din_serie and Din.
  - The controller observes Dout.
- Arbitration, counters and the FSM live in this module.

## Test plan
All scenarios use N_BITS=4, BIT_CYCLES=2 unless stated.
- Reset asserted -> serial_out=1, busy=0, tx_ready=0, rx_valid=0, register 0.
- Send 4'b1011:
  - tx_valid held -> tx_ready for 1 cycle.
  - serial_out over cycles 1–8 = 1,1,1,1,0,0,1,1.
  - Then 1 and busy=0 at cycle 9.
- Receive:
  - rx_req held, serial_in LSB-first bits 0,1,1,0 (2 cycles each) -> rx_valid at cycle 9 with rx_data=4'b0110.
  - With rx_ready=0 for 3 cycles, data holds stable.
  - rx_ready=1 -> IDLE next cycle.
- Arbitration:
  - tx_valid and rx_req both held continuously from reset -> grants alternate TX, RX, TX.
  - Each grant is separated by one IDLE cycle.
- Reset mid-transfer:
  - Reset asserted at cycle 3 of a TX -> serial_out=1 and busy=0 immediately.
  - After release, a new tx_valid is accepted in the first cycle.
- Back-to-back TX, BIT_CYCLES=1:
  - tx_valid held with 4'hF then 4'h0.
  - Accepts at cycles 0 and 5.
  - serial_out = 1,1,1,1 (cycles 1–4), 1 (IDLE), then 0,0,0,0.
